// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;

    localparam int DATA_BITS = 16;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner select for the SDRAM arbiter.
// Fixed mode: lowest pending index wins.
// Rotate mode: search starts at ptr+1 (mod NUM_CH) and wraps.
module sdram_arb_pick #(
    parameter int  NUM_CH = 3,
    parameter bit  ROTATE = 1'b0,
    localparam int GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [GW-1:0]     ptr,
    output logic              valid,
    output logic [GW-1:0]     idx
);

    logic [GW-1:0] cand;

    // Scan from the least to the most preferred slot so the preferred hit is written last.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        valid = |pending;
        idx   = '0;
        cand  = '0;
        if (ROTATE) begin
            for (int k = NUM_CH; k >= 1; k--) begin
                cand = GW'((int'(ptr) + k) % NUM_CH);
                if (pending[cand]) idx = cand;
            end
        end else begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (pending[i]) idx = GW'(i);
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Serialises toggle-handshake requests from several requesters onto one
// SDRAM controller port and returns read data per channel.
// Optional build macro SDRAM_ARB_ROUND_ROBIN_EN selects rotating priority
// (last-served pointer); undefined gives fixed priority, channel 0 first.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int  ADDR_BITS = 23,
    parameter int  NUM_CH    = 3,
    localparam int GW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CH-1:0]                   ch_req,
    output logic [NUM_CH-1:0]                   ch_ack,
    input  logic [NUM_CH-1:0]                   ch_we,
    input  logic [NUM_CH-1:0][ADDR_BITS-1:0]    ch_address,
    input  logic [NUM_CH-1:0][DATA_BITS-1:0]    ch_data_write,
    output logic [NUM_CH-1:0][DATA_BITS-1:0]    ch_data_read,
    output logic                                mem_req,
    input  logic                                mem_ack,
    output logic                                mem_we,
    output logic [ADDR_BITS-1:0]                mem_address,
    output logic [DATA_BITS-1:0]                mem_data_write,
    input  logic [DATA_BITS-1:0]                mem_data_read,
    output logic [GW-1:0]                       grant,
    output logic                                busy
);

    arb_state_t          state, state_d;
    logic [NUM_CH-1:0]   pending;
    logic                win_valid;
    logic [GW-1:0]       win_idx;
    logic [GW-1:0]       rr_ptr;
    logic                issue;
    logic                complete;

    assign pending = ch_req ^ ch_ack;
    assign busy    = (state == WAIT);

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    localparam bit ROTATE = 1'b1;

    // Last-served pointer; the next search begins just after it.
    always_ff @(posedge clk) begin
        if (rst)        rr_ptr <= '0;
        else if (issue) rr_ptr <= win_idx;
    end
`else
    localparam bit ROTATE = 1'b0;

    assign rr_ptr = '0;
`endif

    sdram_arb_pick #(
        .NUM_CH (NUM_CH),
        .ROTATE (ROTATE)
    ) u_pick (
        .pending (pending),
        .ptr     (rr_ptr),
        .valid   (win_valid),
        .idx     (win_idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next state plus one-cycle issue/complete strobes.
    always_comb begin
        state_d  = state;
        issue    = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    issue   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_req == mem_ack) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory-side request, per-channel acknowledge and read-data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: ch_data_read is a small register bank, not a RAM, so it is safe to reset.
            ch_ack         <= '0;
            ch_data_read   <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_address    <= '0;
            mem_data_write <= '0;
            grant          <= '0;
        end else begin
            if (issue) begin
                mem_req        <= ~mem_req;
                mem_we         <= ch_we[win_idx];
                mem_address    <= ch_address[win_idx];
                mem_data_write <= ch_data_write[win_idx];
                grant          <= win_idx;
            end
            if (complete) begin
                // mem_we still holds this transaction's direction.
                if (!mem_we) ch_data_read[grant] <= mem_data_read;
                ch_ack[grant] <= ~ch_ack[grant];
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed steps plus a randomized
// phase, checked against a transaction-level reference of the arbiter.
module tb_sdram_arbiter;

    localparam int NCH = 3;
    localparam int AB  = 23;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic          we;
        logic [AB-1:0] addr;
        logic [15:0]   data;
    } cmd_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NCH-1:0]          ch_req;
    logic [NCH-1:0]          ch_ack;
    logic [NCH-1:0]          ch_we;
    logic [NCH-1:0][AB-1:0]  ch_address;
    logic [NCH-1:0][15:0]    ch_data_write;
    logic [NCH-1:0][15:0]    ch_data_read;
    logic                    mem_req;
    logic                    mem_ack;
    logic                    mem_we;
    logic [AB-1:0]           mem_address;
    logic [15:0]             mem_data_write;
    logic [15:0]             mem_data_read;
    logic [1:0]              grant;
    logic                    busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(.ADDR_BITS(AB), .NUM_CH(NCH)) dut (
        .clk            (clk),
        .rst            (rst),
        .ch_req         (ch_req),
        .ch_ack         (ch_ack),
        .ch_we          (ch_we),
        .ch_address     (ch_address),
        .ch_data_write  (ch_data_write),
        .ch_data_read   (ch_data_read),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .mem_we         (mem_we),
        .mem_address    (mem_address),
        .mem_data_write (mem_data_write),
        .mem_data_read  (mem_data_read),
        .grant          (grant),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Initial memory contents seen by both the controller and the reference.
    function automatic logic [15:0] dflt(input int a);
        return (a == 32'h123) ? 16'hBEEF : (a[15:0] ^ 16'hA5C3);
    endfunction

    // Reference winner: first pending channel in priority order.
    function automatic int pick_ch(input logic [2:0] p, input int last);
        int start = RR ? last + 1 : 0;
        for (int k = 0; k < NCH; k++) begin
            if (p[(start + k) % NCH]) return (start + k) % NCH;
        end
        return 0;
    endfunction

    // ---------------- SDRAM controller model ----------------
    logic [15:0] ctl_mem [int];
    int ctl_cnt = 0;
    int ctl_lat = 0;
    int fixed_lat = 4;
    bit rand_lat = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            mem_ack       = 1'b0;
            mem_data_read = 16'h0;
            ctl_cnt       = 0;
            ctl_lat       = 0;
        end else if (mem_req != mem_ack) begin
            if (ctl_cnt < (rand_lat ? ctl_lat : fixed_lat)) begin
                ctl_cnt++;
                mem_data_read = 16'($urandom);
            end else begin
                if (mem_we) begin
                    ctl_mem[int'(mem_address)] = mem_data_write;
                    mem_data_read = 16'($urandom);
                end else begin
                    mem_data_read = ctl_mem.exists(int'(mem_address)) ?
                                    ctl_mem[int'(mem_address)] : dflt(int'(mem_address));
                end
                mem_ack = mem_req;
                ctl_cnt = 0;
                ctl_lat = $urandom_range(0, 5);
            end
        end else begin
            mem_data_read = 16'($urandom);
        end
    end

    // ---------------- Requesters (command tables) ----------------
    cmd_t cmd_mem [NCH][64];
    int   cmd_cnt [NCH] = '{default: 0};
    int   rd_idx  [NCH] = '{default: 0};
    bit   holdoff = 1'b0;
    logic [15:0] ref_mem [int];

    always @(negedge clk) begin
        if (rst) begin
            ch_req        = '0;
            ch_we         = '0;
            ch_address    = '0;
            ch_data_write = '0;
            for (int i = 0; i < NCH; i++) rd_idx[i] = cmd_cnt[i];
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_req[i] == ch_ack[i] && rd_idx[i] < cmd_cnt[i] &&
                    (!holdoff || $urandom_range(0, 1) == 0)) begin
                    ch_we[i]         = cmd_mem[i][rd_idx[i]].we;
                    ch_address[i]    = cmd_mem[i][rd_idx[i]].addr;
                    ch_data_write[i] = cmd_mem[i][rd_idx[i]].data;
                    if (ch_we[i]) ref_mem[int'(ch_address[i])] = ch_data_write[i];
                    rd_idx[i]++;
                    ch_req[i] = ~ch_req[i];
                end
            end
        end
    end

    function automatic logic [15:0] ref_read(input logic [AB-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(int'(a));
    endfunction

    // ---------------- Reference model / per-edge monitor ----------------
    bit            m_busy = 1'b0;
    int            m_cur = 0;
    logic          m_we = 1'b0;
    logic [AB-1:0] m_addr = '0;
    int            rr_last = 0;
    logic [15:0]   exp_rd [NCH] = '{default: 16'h0};
    int            grant_log [$];

    logic          rst_s, mreq_s, match_s, exp_issue;
    logic [2:0]    pend_s, ack_s;
    int            win;

    always @(posedge clk) begin
        rst_s     = rst;
        pend_s    = ch_req ^ ch_ack;
        ack_s     = ch_ack;
        mreq_s    = mem_req;
        match_s   = m_busy && (mem_req == mem_ack);
        exp_issue = !m_busy && (pend_s != 3'b000);
        win       = pick_ch(pend_s, rr_last);
        #1;
        if (rst_s) begin
            m_busy  = 1'b0;
            rr_last = 0;
            for (int i = 0; i < NCH; i++) exp_rd[i] = 16'h0;
        end else begin
            check("issue_timing", 32'(mem_req ^ mreq_s), 32'(exp_issue));
            if (exp_issue) begin
                check("grant", 32'(grant), win);
                check("mem_address", 32'(mem_address), 32'(ch_address[win]));
                check("mem_we", 32'(mem_we), 32'(ch_we[win]));
                check("mem_data_write", 32'(mem_data_write), 32'(ch_data_write[win]));
                check("busy_set", 32'(busy), 1);
                m_busy  = 1'b1;
                m_cur   = win;
                m_we    = ch_we[win];
                m_addr  = ch_address[win];
                rr_last = win;
                grant_log.push_back(win);
            end
            check("ack_toggle", 32'(ch_ack ^ ack_s), match_s ? (32'h1 << m_cur) : 32'h0);
            if (match_s) begin
                m_busy = 1'b0;
                if (!m_we) exp_rd[m_cur] = ref_read(m_addr);
                check("busy_clear", 32'(busy), 0);
            end
            for (int i = 0; i < NCH; i++) check("ch_data_read", 32'(ch_data_read[i]), 32'(exp_rd[i]));
        end
    end

    // ---------------- Directed + random stimulus ----------------
    task automatic push(input int ch, input logic we, input logic [AB-1:0] a, input logic [15:0] d);
        cmd_mem[ch][cmd_cnt[ch]] = '{we: we, addr: a, data: d};
        cmd_cnt[ch]++;
    endtask

    function automatic bit all_issued();
        for (int i = 0; i < NCH; i++) if (rd_idx[i] != cmd_cnt[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string tag, input int bound);
        logic done = 1'b0;
        for (int n = 0; n < bound && !done; n++) begin
            @(posedge clk); #2;
            done = all_issued() && (ch_req === ch_ack) && !busy;
        end
        check(tag, 32'(done), 1);
    endtask

    task automatic wait_busy(input string tag, input int bound);
        logic done = 1'b0;
        for (int n = 0; n < bound && !done; n++) begin
            @(posedge clk); #2;
            done = busy;
        end
        check(tag, 32'(done), 1);
    endtask

    int s;
    int exp_seq [9];
    logic [2:0] ack_before;

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        check("rst_ch_ack", 32'(ch_ack), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_address", 32'(mem_address), 0);
        check("rst_mem_data_write", 32'(mem_data_write), 0);
        check("rst_ch_data_read", 32'(|ch_data_read), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk); rst = 1'b0;

        // Single read on channel 1.
        push(1, 1'b0, 23'h000123, 16'h0);
        wait_idle("t1_idle", 100);
        check("t1_rd1", 32'(ch_data_read[1]), 32'hBEEF);
        check("t1_ack", 32'(ch_ack), 32'b010);
        check("t1_rd0", 32'(ch_data_read[0]), 0);
        check("t1_rd2", 32'(ch_data_read[2]), 0);

        // Write on channel 2 at the top address.
        push(2, 1'b1, 23'h7FFFFF, 16'h55AA);
        wait_busy("t3_busy", 50);
        check("t3_mem_we", 32'(mem_we), 1);
        check("t3_mem_data_write", 32'(mem_data_write), 32'h55AA);
        check("t3_mem_address", 32'(mem_address), 32'h7FFFFF);
        wait_idle("t3_idle", 100);
        check("t3_rd2", 32'(ch_data_read[2]), 0);
        check("t3_ack", 32'(ch_ack), 32'b110);

        // ch0 and ch2 pending together: ch0 is next in either priority mode.
        s = grant_log.size();
        push(0, 1'b0, 23'h000010, 16'h0);
        push(2, 1'b0, 23'h200005, 16'h0);
        wait_idle("t2_idle", 100);
        check("t2_ngrant", grant_log.size() - s, 2);
        check("t2_first", grant_log[s], 0);
        check("t2_second", grant_log[s+1], 2);
        check("t2_ack", 32'(ch_ack), 32'b011);
        check("t2_rd0", 32'(ch_data_read[0]), 32'(dflt(32'h10)));
        check("t2_rd2", 32'(ch_data_read[2]), 32'(dflt(32'h200005)));

        // Reset while waiting on the controller.
        fixed_lat = 20;
        push(0, 1'b0, 23'h000040, 16'h0);
        wait_busy("rst_busy_wait", 50);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #2;
        check("mid_rst_mem_req", 32'(mem_req), 0);
        check("mid_rst_ch_ack", 32'(ch_ack), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_grant", 32'(grant), 0);
        check("mid_rst_rd", 32'(|ch_data_read), 0);
        @(negedge clk); rst = 1'b0;
        fixed_lat = 4;
        push(0, 1'b0, 23'h000041, 16'h0);
        wait_idle("post_rst_idle", 100);
        check("post_rst_ack", 32'(ch_ack), 32'b001);
        check("post_rst_rd0", 32'(ch_data_read[0]), 32'(dflt(32'h41)));

        // All channels re-request continuously for nine grants.
        if (RR) exp_seq = '{1, 2, 0, 1, 2, 0, 1, 2, 0};
        else    exp_seq = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
        s = grant_log.size();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < NCH; c++) push(c, 1'b0, 23'((c << 20) | (r + 32)), 16'h0);
        wait_idle("cont_idle", 300);
        check("cont_ngrant", grant_log.size() - s, 9);
        for (int k = 0; k < 9; k++) check("cont_seq", grant_log[s+k], exp_seq[k]);

        // ch1 re-toggles req on the cycle its ack toggles.
        s = grant_log.size();
        ack_before = ch_ack;
        push(1, 1'b1, 23'h100007, 16'h1234);
        push(1, 1'b0, 23'h100007, 16'h0);
        wait_idle("retog_idle", 100);
        check("retog_ngrant", grant_log.size() - s, 2);
        check("retog_ack1", 32'(ch_ack[1]), 32'(ack_before[1]));
        check("retog_rd1", 32'(ch_data_read[1]), 32'h1234);

        // Randomized traffic, per-channel address regions, random latency and gaps.
        holdoff  = 1'b1;
        rand_lat = 1'b1;
        s = grant_log.size();
        for (int n = 0; n < 30; n++)
            for (int c = 0; c < NCH; c++)
                push(c, 1'($urandom_range(0, 1)), 23'((c << 20) | $urandom_range(0, 15)), 16'($urandom));
        wait_idle("rand_idle", 20000);
        check("rand_ngrant", grant_log.size() - s, 90);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares one SDRAM controller port between several cartridge-side requesters: CHR ROM fetch, PRG ROM fetch, and the MCU loader/save path.
- Every side uses the toggle handshake of the sdram_bus. A request is pending while req != ack.
- Sits between the requester blocks and the SDRAM controller.
- Serialises requests one at a time and returns read data per channel.

Parameters:
ADDR_BITS, 23, word (16-bit) address width on every channel and on the memory side
NUM_CH, 3, number of requester channels; index 0 is highest fixed priority (CHR)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
ch_req  in  NUM_CH  per-channel request toggle
ch_ack  out  NUM_CH  per-channel acknowledge toggle
ch_we  in  NUM_CH  per-channel write enable, sampled at grant
ch_address  in  NUM_CH x ADDR_BITS  per-channel word address, sampled at grant
ch_data_write  in  NUM_CH x 16  per-channel write data, sampled at grant
ch_data_read  out  NUM_CH x 16  per-channel read data register
mem_req  out  1  request toggle to SDRAM controller
mem_ack  in  1  acknowledge toggle from SDRAM controller
mem_we  out  1  write enable to controller
mem_address  out  ADDR_BITS  word address to controller
mem_data_write  out  16  write data to controller
mem_data_read  in  16  read data from controller, valid when mem_ack == mem_req
grant  out  $clog2(NUM_CH)  index of channel currently or last served
busy  out  1  high while a memory transaction is outstanding

Behaviour:
- pending[i] = ch_req[i] ^ ch_ack[i].
- Requesters hold we, address and data_write stable while pending.
- Reset values: ch_ack=0, mem_req=0, mem_we=0, mem_address=0, mem_data_write=0, ch_data_read=0, grant=0, busy=0, state=IDLE.
- Requesters and the SDRAM controller are reset by the same rst, so all toggles are equal after reset.
- State IDLE:
  - If any pending bit is set, pick a winner: the lowest index in the default build, or the ROUND_ROBIN_EN selection.
  - On the same edge: latch the winner's we, address and data_write into the mem_* outputs, toggle mem_req, set grant=winner and busy=1, then go to WAIT.
  - If nothing is pending, stay in IDLE.
- State WAIT:
  - When mem_req == mem_ack, capture mem_data_read into ch_data_read[grant] (reads only; a write leaves the register unchanged).
  - On the same edge: toggle ch_ack[grant], set busy=0, return to IDLE.
- Latency:
  - Pending is visible at edge N; mem_req toggles at edge N+1.
  - mem_ack matches at edge M; ch_ack toggles and data is valid at edge M+1.
  - Minimum one IDLE cycle between consecutive transactions.
- Simultaneous pending requests: exactly one is granted. The others stay pending with no loss and are served in later IDLE cycles.
- A channel's req toggling in the same cycle its ack toggles is seen as a new request on the next IDLE evaluation.
- A req toggle on a non-granted channel during WAIT is queued, not dropped.
- ch_data_read[i] changes only on completion of a read for channel i.
- Reset mid-transaction abandons the transaction. All outputs return to reset values on the next edge. The in-flight channel's ack is forced to 0 and not toggled.
- NUM_CH=1 is legal: grant is 1 bit, constant 0.

Optional Feature:
- Macro SDRAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Rotating priority; a last-served pointer, reset 0, updates on every grant.
  - Search starts at pointer+1, modulo NUM_CH, wrapping.
  - No channel waits more than NUM_CH-1 grants.
- Undefined: fixed priority, lowest index wins; channel 0 (CHR) may starve higher indices. No pointer register exists.

Decomposition:
- Package sdram_arb_pkg:
  - state enum arb_state_t {IDLE, WAIT}.
  - Localparam DATA_BITS=16.
- One sub-module, sdram_arb_pick: combinational winner select from pending and pointer. It outputs a valid flag and an index, and has both fixed and rotate modes.
- The FSM and registers stay in sdram_arbiter.

Test Plan:
- Reset, then ch_req[1] toggles, read at 0x000123, controller returns 0xBEEF after 4 cycles -> mem_req toggles 1 cycle after pending; ch_data_read[1]=0xBEEF and ch_ack[1] toggles 1 cycle after mem_ack; others unchanged.
- ch0 and ch2 toggle in the same cycle (fixed build) -> ch0 served first; ch2 mem_req toggles after one IDLE cycle; both acks eventually toggle.
- ch2 write we=1, data 0x55AA, address 0x7FFFFF -> mem_we=1, mem_data_write=0x55AA, mem_address=0x7FFFFF; ch_data_read[2] stays 0 after ack.
- ROUND_ROBIN_EN, all three channels re-request continuously for 9 grants -> grant sequence 1,2,0,1,2,0,...; no channel served twice in a row while others are pending.
- rst asserted in WAIT -> next edge mem_req=0, ch_ack=0, busy=0, state IDLE; a fresh request after release completes normally.
- ch1 re-toggles req on the cycle its ack toggles -> second transaction issued on the following IDLE; no lost request.
